// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide unit, one bit per clock.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only while idle
//   funct3        : 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                   100 DIV 101 DIVU 110 REM 111 REMU
//   op_a, op_b    : rs1 / rs2 operands, latched on start
//   rd_in         : destination register, latched on start
//   busy          : high while calculating and during the done cycle
//   done          : one-cycle pulse; result and rd_out valid
//   result, rd_out: held until the next done or reset
// Optional build macro MULDIV_EARLY_OUT_EN: divide by zero, signed
// overflow and multiply by zero skip the iterations (done in cycle 1).
module mul_div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d, div0_q, div0_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [4:0]          rd_cap_q, rd_cap_d, rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic                sgn_a, sgn_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       msum, rshift;
  logic [XLEN-1:0]     rdiff, rem_step, quo, rmd, final_res;
  logic                take;
  logic [2*XLEN-1:0]   acc_step, prod;

  // Operand decode on the request side: magnitudes of signed operands.
  always_comb begin
    sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    sgn_b = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    mag_a = (sgn_a && op_a[XLEN-1]) ? -op_a : op_a;
    mag_b = (sgn_b && op_b[XLEN-1]) ? -op_b : op_b;
  end

  // One iteration. Multiply: acc = {partial product, remaining multiplier},
  // shifted right with the carry of the add. Divide: acc low half holds the
  // dividend, shifted left while quotient bits enter at the bottom.
  always_comb begin
    msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rshift = {rem_q, acc_q[XLEN-1]};
    take   = rshift >= {1'b0, opnd_q};
    rdiff  = rshift[XLEN-1:0] - opnd_q;
    if (f3_q[2]) begin
      acc_step = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], take};
      rem_step = take ? rdiff : rshift[XLEN-1:0];
    end else begin
      acc_step = {msum, acc_q[XLEN-1:1]};
      rem_step = rem_q;
    end
    prod = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
    quo  = acc_step[XLEN-1:0];
    rmd  = rem_step;
    if (!f3_q[2]) begin
      final_res = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (!f3_q[1]) begin
      // A zero divisor yields an all-ones quotient from the core; keep it unsigned.
      final_res = div0_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quo : quo);
    end else begin
      final_res = neg_a_q ? -rmd : rmd;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic            early;
  logic [XLEN-1:0] early_res;

  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (!funct3[2]) begin
      early = (op_a == '0) || (op_b == '0);
    end else if (op_b == '0) begin
      early     = 1'b1;
      early_res = funct3[1] ? op_a : '1;
    end else if (!funct3[0] && (op_a == MIN_NEG) && (op_b == '1)) begin
      early     = 1'b1;
      early_res = funct3[1] ? '0 : MIN_NEG;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    rd_cap_d = rd_cap_q;
    rd_d     = rd_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d     = funct3;
          neg_a_d  = sgn_a && op_a[XLEN-1];
          neg_b_d  = sgn_b && op_b[XLEN-1];
          div0_d   = (op_b == '0);
          rd_cap_d = rd_in;
          count_d  = '0;
          rem_d    = '0;
          opnd_d   = funct3[2] ? mag_b : mag_a;
          acc_d    = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
          state_d  = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = early_res;
            rd_d     = rd_in;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d   = acc_step;
        rem_d   = rem_step;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = final_res;
          rd_d     = rd_cap_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      rd_cap_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      rd_cap_q <= rd_cap_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven, hand-sequenced and randomized checks of
// mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] word_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] funct3;
  word_t      op_a, op_b, result;
  logic [4:0] rd_in, rd_out;
  logic       busy, done;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic word_t min_neg();
    word_t m;
    m = '0;
    m[XLEN-1] = 1'b1;
    return m;
  endfunction

  // Reference: plain wide arithmetic plus the RISC-V special cases.
  function automatic word_t ref_model(input logic [2:0] f, input word_t a, input word_t b);
    logic signed [2*XLEN-1:0] pa, pb, p;
    logic [2*XLEN-1:0] pu;
    word_t ones;
    ones = '1;
    pa = $signed({{XLEN{a[XLEN-1]}}, a});
    case (f)
      3'b000: begin pu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; return pu[XLEN-1:0]; end
      3'b001: begin pb = $signed({{XLEN{b[XLEN-1]}}, b}); p = pa * pb; return p[2*XLEN-1:XLEN]; end
      3'b010: begin pb = $signed({{XLEN{1'b0}}, b}); p = pa * pb; return p[2*XLEN-1:XLEN]; end
      3'b011: begin pu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; return pu[2*XLEN-1:XLEN]; end
      3'b100: begin
        if (b == '0) return ones;
        if (a == min_neg() && b == ones) return min_neg();
        return word_t'($signed(a) / $signed(b));
      end
      3'b101: return (b == '0) ? ones : a / b;
      3'b110: begin
        if (b == '0) return a;
        if (a == min_neg() && b == ones) return '0;
        return word_t'($signed(a) % $signed(b));
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input word_t a, input word_t b);
    logic early;
    word_t ones;
    ones = '1;
    early = (!f[2] && (a == '0 || b == '0)) || (f[2] && b == '0) ||
            (f[2] && !f[0] && a == min_neg() && b == ones);
`ifdef MULDIV_EARLY_OUT_EN
    if (early) return 1;
`else
    if (early) return XLEN + 1;
`endif
    return XLEN + 1;
  endfunction

  // Issues one request and returns the cycle (relative to start) of done.
  task automatic run_op(input logic [2:0] f, input word_t a, input word_t b, input logic [4:0] rd,
                        output word_t res, output logic [4:0] rdo, output int lat, output logic busy_ok);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: the unit must work from latched copies.
    funct3 = 3'($urandom); op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; rd_in = 5'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    res = result;
    rdo = rd_out;
  endtask

  task automatic op_check(input string name, input logic [2:0] f, input word_t a, input word_t b,
                          input logic [4:0] rd, input word_t exp);
    word_t res;
    logic [4:0] rdo;
    int lat;
    logic bok;
    run_op(f, a, b, rd, res, rdo, lat, bok);
    check({name, ":result"}, res, exp);
    check({name, ":rd_out"}, word_t'(rdo), word_t'(rd));
    check({name, ":latency"}, word_t'(lat), word_t'(exp_lat(f, a, b)));
    check({name, ":busy_window"}, word_t'(bok), word_t'(1));
    @(posedge clk); #1;
    check({name, ":done_pulse"}, word_t'(done), word_t'(0));
    check({name, ":busy_after"}, word_t'(busy), word_t'(0));
    check({name, ":hold"}, result, exp);
  endtask

  function automatic word_t rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return word_t'(1);
      2: return '1;
      3: return min_neg();
      4: return word_t'($urandom_range(0, 300));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    string      name;
    logic [2:0] f;
    word_t      a;
    word_t      b;
    logic [4:0] rd;
    word_t      exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int    cyc;
    logic  seen;
    logic [2:0] rf;
    word_t ra, rb;

    vecs.push_back('{"mul_7x-3",     3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,  64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{"mulhu_ones",   3'b011, '1, '1, 5'd1,                           64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"mulh_m1m1",    3'b001, '1, '1, 5'd2,                           64'd0});
    vecs.push_back('{"mulhsu_m1x2",  3'b010, '1, 64'd2, 5'd3,                        64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"div_-7_2",     3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4,   64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{"rem_-7_2",     3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,   64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"divu_100_7",   3'b101, 64'd100, 64'd7, 5'd7,                   64'd14});
    vecs.push_back('{"remu_100_7",   3'b111, 64'd100, 64'd7, 5'd8,                   64'd2});
    vecs.push_back('{"divu_by0",     3'b101, 64'd100, 64'd0, 5'd9,                   64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"rem_by0",      3'b110, 64'd100, 64'd0, 5'd10,                  64'd100});
    vecs.push_back('{"div_-5_by0",   3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd11,  64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"remu_by0",     3'b111, 64'd100, 64'd0, 5'd12,                  64'd100});
    vecs.push_back('{"div_ovf",      3'b100, 64'h8000_0000_0000_0000, '1, 5'd13,     64'h8000_0000_0000_0000});
    vecs.push_back('{"rem_ovf",      3'b110, 64'h8000_0000_0000_0000, '1, 5'd14,     64'd0});
    vecs.push_back('{"mul_zero_x0",  3'b000, 64'd0, 64'd5, 5'd0,                     64'd0});
    vecs.push_back('{"mulhu_big",    3'b011, 64'h8000_0000_0000_0000, 64'd4, 5'd31, 64'd2});

    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:busy",   word_t'(busy),   word_t'(0));
    check("reset:done",   word_t'(done),   word_t'(0));
    check("reset:result", result,          word_t'(0));
    check("reset:rd_out", word_t'(rd_out), word_t'(0));
    rst = 1'b0;

    foreach (vecs[i]) op_check(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    // Second start in cycle 10 and a start held in the done cycle are both ignored.
    @(negedge clk);
    funct3 = 3'b101; op_a = 64'd1000; op_b = 64'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    repeat (9) begin @(posedge clk); #1; cyc++; end
    funct3 = 3'b000; op_a = 64'd5; op_b = 64'd6; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc++;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("ignore:latency", word_t'(cyc), word_t'(XLEN + 1));
    check("ignore:result",  result,       word_t'(333));
    check("ignore:rd_out",  word_t'(rd_out), word_t'(9));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignore_in_done:busy", word_t'(busy), word_t'(0));
    @(posedge clk); #1;
    check("ignore_in_done:busy2", word_t'(busy), word_t'(0));
    check("ignore_in_done:done",  word_t'(done), word_t'(0));

    // Reset in cycle 30 of a DIVU aborts it without a done pulse.
    @(negedge clk);
    funct3 = 3'b101; op_a = '1; op_b = 64'd7; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort:busy",   word_t'(busy),   word_t'(0));
    check("abort:done",   word_t'(done),   word_t'(0));
    check("abort:result", result,          word_t'(0));
    check("abort:rd_out", word_t'(rd_out), word_t'(0));
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("abort:no_done", word_t'(seen), word_t'(0));
    op_check("after_abort", 3'b101, 64'd100, 64'd7, 5'd3, 64'd14);

    for (int k = 0; k < 60; k++) begin
      rf = 3'($urandom);
      ra = rand_operand();
      rb = rand_operand();
      op_check($sformatf("rand%0d_f%0d", k, rf), rf, ra, rb, 5'($urandom), ref_model(rf, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
